// File: rtl/approx_mult_err_monitor.sv
// Error-statistics monitor for the 8x8 approximate multiplier family.
// Accumulates a saturating sum, the maximum and the count of errors over a batch of samples.
module approx_mult_err_monitor #(
    parameter int N_SAMPLES = 256,
    parameter int ACC_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic [15:0]      r_approx,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] sum_abs_err,
    output logic [15:0]      max_abs_err,
    output logic [15:0]      err_count,
    output logic [15:0]      sample_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [15:0] LAST = 16'(N_SAMPLES);

    state_t state, state_next;

    logic              accept;
    logic              v1, v2;
    logic [15:0]       exact1, r1;
    logic [15:0]       abs2;
    logic              neq2;
    logic signed [16:0] diff;
    logic [15:0]       abs_comb;
    logic [ACC_W:0]    sum_wide;
    logic [ACC_W-1:0]  sum_sat;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_next = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = (sample_count < LAST);
                if (in_valid && in_ready && (sample_count == LAST - 16'd1))
                    state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!v1 && !v2)
                    state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    assign accept = in_valid && in_ready;

    // The low 16 bits of a negative difference, negated, give its magnitude.
    assign diff     = $signed({1'b0, exact1}) - $signed({1'b0, r1});
    assign abs_comb = diff[16] ? (16'd0 - diff[15:0]) : diff[15:0];

    assign sum_wide = {1'b0, sum_abs_err} + {{(ACC_W - 15){1'b0}}, abs2};
    assign sum_sat  = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            v1           <= 1'b0;
            v2           <= 1'b0;
            exact1       <= '0;
            r1           <= '0;
            abs2         <= '0;
            neq2         <= 1'b0;
            sum_abs_err  <= '0;
            max_abs_err  <= '0;
            err_count    <= '0;
            sample_count <= '0;
        end else begin
            v1 <= accept;
            if (accept) begin
                exact1       <= {8'd0, a} * {8'd0, b};
                r1           <= r_approx;
                sample_count <= sample_count + 16'd1;
            end

            v2 <= v1;
            if (v1) begin
                abs2 <= abs_comb;
                neq2 <= (exact1 != r1);
            end

            if (v2) begin
                sum_abs_err <= sum_sat;
                if (abs2 > max_abs_err)
                    max_abs_err <= abs2;
                err_count <= err_count + {15'd0, neq2};
            end

            // The pipeline is empty in IDLE, so clearing here never races an update.
            if (state == IDLE && start) begin
                sum_abs_err  <= '0;
                max_abs_err  <= '0;
                err_count    <= '0;
                sample_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Directed bench for approx_mult_err_monitor: one instance per batch configuration,
// table-driven batches plus hand-written reset and start-ignore sequences.
module tb_approx_mult_err_monitor;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] r;
        logic        valid;
    } sample_t;

    typedef struct {
        int          inst;
        int          first;
        int          count;
        int          start_at;
        bit          start_in_done;
        logic [31:0] sum;
        logic [31:0] max;
        logic [31:0] err;
        logic [31:0] acc;
    } batch_t;

    function automatic int nsOf(input int g);
        case (g)
            0: return 4;
            1: return 3;
            2: return 5;
            3: return 2;
            default: return 8;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  start_v;
    logic [7:0]  a, b;
    logic [15:0] r_approx;

    logic [4:0]  in_ready_v, busy_v, done_v;
    logic [31:0] sum_v [5];
    logic [15:0] max_v [5];
    logic [15:0] err_v [5];
    logic [15:0] cnt_v [5];

    int checks = 0;
    int fails  = 0;

    sample_t smp[$];
    batch_t  bt_tab[6];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int NS = nsOf(g);
        localparam int AW = (g == 3) ? 16 : 32;
        logic [AW-1:0] sum_g;
        approx_mult_err_monitor #(.N_SAMPLES(NS), .ACC_W(AW)) dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start_v[g]),
            .in_valid     (in_valid),
            .in_ready     (in_ready_v[g]),
            .a            (a),
            .b            (b),
            .r_approx     (r_approx),
            .busy         (busy_v[g]),
            .done         (done_v[g]),
            .sum_abs_err  (sum_g),
            .max_abs_err  (max_v[g]),
            .err_count    (err_v[g]),
            .sample_count (cnt_v[g])
        );
        assign sum_v[g] = 32'(sum_g);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic addSample(input logic [7:0] sa, input logic [7:0] sb, input logic [15:0] sr, input logic sv);
        sample_t t;
        t.a = sa;
        t.b = sb;
        t.r = sr;
        t.valid = sv;
        smp.push_back(t);
    endtask

    task automatic applyStimulus(input batch_t bt);
        int      acc;
        int      cyc;
        sample_t s;
        start_v[bt.inst] = 1'b1;
        @(negedge clk);
        start_v[bt.inst] = 1'b0;
        checkOutput("busy after start", {31'd0, busy_v[bt.inst]}, 32'd1);
        checkOutput("count cleared", {16'd0, cnt_v[bt.inst]}, 32'd0);
        acc = 0;
        for (int i = 0; i < bt.count; i++) begin
            s = smp[bt.first + i];
            a = s.a;
            b = s.b;
            r_approx = s.r;
            in_valid = s.valid;
            start_v[bt.inst] = (i == bt.start_at);
            if (in_valid && in_ready_v[bt.inst])
                acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        start_v[bt.inst] = 1'b0;
        checkOutput("accept count", acc, bt.acc);
        checkOutput("in_ready after last accept", {31'd0, in_ready_v[bt.inst]}, 32'd0);
        checkOutput("busy in drain", {31'd0, busy_v[bt.inst]}, 32'd1);

        // Bounded wait for done.
        cyc = 0;
        while (!done_v[bt.inst] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("done latency", cyc, 32'd3);
        checkOutput("busy with done", {31'd0, busy_v[bt.inst]}, 32'd0);
        checkOutput("sum_abs_err", sum_v[bt.inst], bt.sum);
        checkOutput("max_abs_err", {16'd0, max_v[bt.inst]}, bt.max);
        checkOutput("err_count", {16'd0, err_v[bt.inst]}, bt.err);
        checkOutput("sample_count", {16'd0, cnt_v[bt.inst]}, bt.acc);

        if (bt.start_in_done)
            start_v[bt.inst] = 1'b1;
        @(negedge clk);
        start_v[bt.inst] = 1'b0;
        checkOutput("done one cycle", {31'd0, done_v[bt.inst]}, 32'd0);
        checkOutput("idle after done", {31'd0, busy_v[bt.inst]}, 32'd0);
        checkOutput("sum holds", sum_v[bt.inst], bt.sum);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        in_valid = 1'b0;
        start_v = '0;
        a = '0;
        b = '0;
        r_approx = '0;

        // batch 0: exact products
        addSample(8'd3, 8'd5, 16'd15, 1'b1);
        addSample(8'd255, 8'd255, 16'd65025, 1'b1);
        addSample(8'd0, 8'd9, 16'd0, 1'b1);
        addSample(8'd16, 8'd16, 16'd256, 1'b1);
        // batch 1: constant +3 error
        addSample(8'd10, 8'd7, 16'd73, 1'b1);
        addSample(8'd20, 8'd7, 16'd143, 1'b1);
        addSample(8'd30, 8'd7, 16'd213, 1'b1);
        addSample(8'd40, 8'd7, 16'd283, 1'b1);
        // batch 2: underestimate and mix
        addSample(8'd200, 8'd200, 16'd39000, 1'b1);
        addSample(8'd12, 8'd12, 16'd144, 1'b1);
        addSample(8'd100, 8'd3, 16'd296, 1'b1);
        // batch 3: gaps; invalid slots carry data that would be large errors if taken
        addSample(8'd1, 8'd1, 16'd1, 1'b1);
        addSample(8'd255, 8'd255, 16'd0, 1'b0);
        addSample(8'd255, 8'd255, 16'd0, 1'b0);
        addSample(8'd2, 8'd3, 16'd7, 1'b1);
        addSample(8'd4, 8'd4, 16'd10, 1'b1);
        addSample(8'd255, 8'd255, 16'd0, 1'b0);
        addSample(8'd50, 8'd50, 16'd2400, 1'b1);
        addSample(8'd255, 8'd255, 16'd0, 1'b0);
        addSample(8'd9, 8'd9, 16'd81, 1'b1);
        // batch 4: saturation with a 16-bit accumulator
        addSample(8'd255, 8'd255, 16'd0, 1'b1);
        addSample(8'd255, 8'd255, 16'd0, 1'b1);
        // batch 5: clean run after a mid-batch reset
        addSample(8'd1, 8'd2, 16'd2, 1'b1);
        addSample(8'd3, 8'd4, 16'd12, 1'b1);
        addSample(8'd5, 8'd6, 16'd31, 1'b1);
        addSample(8'd7, 8'd8, 16'd50, 1'b1);
        addSample(8'd9, 8'd10, 16'd90, 1'b1);
        addSample(8'd11, 8'd12, 16'd132, 1'b1);
        addSample(8'd13, 8'd14, 16'd182, 1'b1);
        addSample(8'd15, 8'd16, 16'd240, 1'b1);

        bt_tab[0] = '{inst: 0, first: 0,  count: 4, start_at: -1, start_in_done: 1'b1, sum: 32'd0,     max: 32'd0,     err: 32'd0, acc: 32'd4};
        bt_tab[1] = '{inst: 0, first: 4,  count: 4, start_at: -1, start_in_done: 1'b0, sum: 32'd12,    max: 32'd3,     err: 32'd4, acc: 32'd4};
        bt_tab[2] = '{inst: 1, first: 8,  count: 3, start_at: -1, start_in_done: 1'b0, sum: 32'd1004,  max: 32'd1000,  err: 32'd2, acc: 32'd3};
        bt_tab[3] = '{inst: 2, first: 11, count: 9, start_at: 3,  start_in_done: 1'b0, sum: 32'd107,   max: 32'd100,   err: 32'd3, acc: 32'd5};
        bt_tab[4] = '{inst: 3, first: 20, count: 2, start_at: -1, start_in_done: 1'b0, sum: 32'd65535, max: 32'd65025, err: 32'd2, acc: 32'd2};
        bt_tab[5] = '{inst: 4, first: 22, count: 8, start_at: -1, start_in_done: 1'b0, sum: 32'd7,     max: 32'd6,     err: 32'd2, acc: 32'd8};

        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", {31'd0, in_ready_v[0]}, 32'd0);
        checkOutput("reset busy", {31'd0, busy_v[0]}, 32'd0);
        checkOutput("reset done", {31'd0, done_v[0]}, 32'd0);
        checkOutput("reset sum", sum_v[0], 32'd0);
        checkOutput("reset count", {16'd0, cnt_v[0]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            applyStimulus(bt_tab[i]);

        // Mid-batch reset on the N_SAMPLES = 8 instance.
        start_v[4] = 1'b1;
        @(negedge clk);
        start_v[4] = 1'b0;
        a = 8'd255;
        b = 8'd255;
        r_approx = 16'd0;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        checkOutput("count before reset", {16'd0, cnt_v[4]}, 32'd3);
        checkOutput("sum three edges after first accept", sum_v[4], 32'd65025);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid reset in_ready", {31'd0, in_ready_v[4]}, 32'd0);
        checkOutput("mid reset busy", {31'd0, busy_v[4]}, 32'd0);
        checkOutput("mid reset done", {31'd0, done_v[4]}, 32'd0);
        checkOutput("mid reset sum", sum_v[4], 32'd0);
        checkOutput("mid reset max", {16'd0, max_v[4]}, 32'd0);
        checkOutput("mid reset err", {16'd0, err_v[4]}, 32'd0);
        checkOutput("mid reset count", {16'd0, cnt_v[4]}, 32'd0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_v[4])
                seen++;
        end
        checkOutput("no done after reset", seen, 32'd0);
        checkOutput("sum stays clear after reset", sum_v[4], 32'd0);

        applyStimulus(bt_tab[5]);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/approx_mult_err_monitor.md
Name: approx_mult_err_monitor

Overview:
- Sequential stage directly downstream of the 8x8 approximate multiplier family.
- Consumes each operand pair (a, b) together with the approximate product R, computes the exact product internally, and accumulates error statistics over a programmed batch of samples.
- Statistics: sum of absolute error, max absolute error, count of erroneous samples.
- Used in FPGA characterisation builds to measure MED/ER of a multiplier configuration on hardware.

Parameters:
- N_SAMPLES, 256: samples per batch; legal range 1..65535.
- ACC_W, 32: width of the absolute-error sum accumulator; legal range 16..48.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a new batch when idle or done
- in_valid  in  1  sample present on a/b/r_approx
- in_ready  out  1  monitor accepts a sample this cycle
- a  in  8  multiplicand fed to the multiplier under test
- b  in  8  multiplier operand fed to the multiplier under test
- r_approx  in  16  product from the multiplier under test for (a, b)
- busy  out  1  batch in progress (RUN or DRAIN)
- done  out  1  one-cycle pulse when batch statistics are final
- sum_abs_err  out  ACC_W  saturating sum of |a*b - r_approx|
- max_abs_err  out  16  largest |a*b - r_approx| in the batch
- err_count  out  16  number of samples with r_approx != a*b
- sample_count  out  16  samples accepted in the current batch

Behaviour:
- Reset: state IDLE; all outputs 0 (in_ready, busy, done, sum_abs_err, max_abs_err, err_count, sample_count); pipeline valid bits cleared. Reset mid-batch aborts the batch; no done pulse.
- FSM states:
  - IDLE: start -> RUN, all statistics and sample_count cleared in that same edge.
  - RUN: in_ready = 1 while sample_count < N_SAMPLES. Accepting the N_SAMPLES-th sample -> DRAIN.
  - DRAIN: in_ready = 0. When both pipeline stages are empty -> DONE.
  - DONE: done = 1 for exactly one cycle, then -> IDLE. Statistics hold until the next start.
- Handshake:
  - A sample is accepted on a rising edge where in_valid && in_ready.
  - in_ready depends only on state and sample_count, never on in_valid.
  - in_valid gaps of any length are allowed.
- start while busy is ignored. start in the DONE cycle is ignored.
- Pipeline:
  - Stage 1 (accept edge): register exact = a*b (16 bit, unsigned) and r_approx; sample_count += 1.
  - Stage 2: register abs_err = |exact - r_approx| (16 bit unsigned; compute with a 17-bit signed difference) and neq = (exact != r_approx).
  - Stage 3: sum_abs_err += abs_err; max_abs_err = max(max_abs_err, abs_err); err_count += neq.
  - Latency from accept edge to statistics update: 3 edges. Fully pipelined, one sample per cycle.
- Arithmetic:
  - sum_abs_err saturates at 2^ACC_W - 1 and never wraps.
  - err_count cannot overflow, because N_SAMPLES <= 65535.
- busy = 1 in RUN and DRAIN. done is never asserted together with busy.

Test Plan:
- Exact input: N_SAMPLES = 4, samples (3,5,15), (255,255,65025), (0,9,0), (16,16,256), in_valid held high -> in_ready high for 4 cycles; done 3 cycles after the last accept (DRAIN then DONE); sum 0, max 0, err_count 0, sample_count 4.
- Constant error: N_SAMPLES = 4, r_approx = a*b + 3 for a = 10, 20, 30, 40, b = 7 -> sum 12, max 3, err_count 4.
- Underestimate and mix: N_SAMPLES = 3, samples (200,200,39000), (12,12,144), (100,3,296). Exact products are 40000, 144, 300 -> sum 1004, max 1000, err_count 2.
- Backpressure/gaps: N_SAMPLES = 5 with in_valid toggling 1,0,0,1,1,0,1,0,1 -> exactly 5 accepts; in_ready drops to 0 right after the 5th; statistics match the golden model. A start pulse issued during RUN has no effect.
- Saturation: ACC_W = 16, N_SAMPLES = 2, samples (255,255,0) twice -> sum_abs_err = 65535, not 64514; max_abs_err = 65025; err_count = 2.
- Reset mid-batch: N_SAMPLES = 8, assert rst after 3 accepts -> next cycle all outputs 0, state IDLE, no done pulse. A new start runs a clean batch whose results match the golden model.
